barrel_shifter: RTL and testbench
=================================

// Module: barrel_shifter
// PURPOSE
//   32-bit barrel shifter for the pRISC/KGP-RISC execute stage (shift instructions).
//   Shifts operand a by shamt: left (logical), right logical, or right arithmetic.
//   Combinational shift core with a registered output: one cycle of latency into the ALU result mux.
// PARAMETERS
//   WIDTH    32               operand/result width in bits; must be a power of two
//   SHAMT_W  $clog2(WIDTH)=5  shift-amount width
// PORTS
//   clk    in   1        single clock; all state updates on the rising edge
//   rst    in   1        reset, synchronous and active-high
//   shamt  in   SHAMT_W  shift amount, unsigned, 0..WIDTH-1
//   a      in   WIDTH    operand to shift
//   type   in   1        0 = logical, 1 = arithmetic (matters only for right shifts)
//   dir    in   1        0 = left, 1 = right
//   out    out  WIDTH    shifted result, registered
// BEHAVIOUR
//   - Reset: on a rising clk edge with rst=1, out <= 0. rst wins over any input.
//   - Latency: inputs are sampled on edge N and the result appears on out after edge N.
//     There is no handshake; a new operation is accepted every cycle.
//   - dir=0 (left): out = a << shamt. Zeros fill the LSBs; type is ignored.
//   - dir=1, type=0 (right logical): out = a >> shamt. Zeros fill the MSBs.
//   - dir=1, type=1 (right arithmetic): out = $signed(a) >>> shamt. a[WIDTH-1] fills the MSBs.
//   - shamt=0: out = a for every dir/type combination.
//   - shamt=WIDTH-1 gives the following:
//       - left: out = {a[0], 0...}
//       - right logical: out = {0..., a[WIDTH-1]}
//       - right arithmetic: every bit of out = a[WIDTH-1]
//   - Shift amounts of WIDTH or more are not representable; there is no saturation logic.
//   - Core is a log2(WIDTH)-stage mux network. Stage k shifts by 2^k when shamt[k]=1.
//     Right shifts use the fill bit (type & a[WIDTH-1]). Left shifts use an input bit-reverse,
//     then a right-shift network with fill 0, then an output bit-reverse.
//   - No X propagation from an unused path: every mux select is fully decoded.
//   - Reset asserted mid-stream clears out on that edge. The first edge after rst deasserts
//     registers the current inputs.
// STRUCTURE
//   - Shared package shift_pkg holds the following:
//       - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1
//       - SHIFT_LOGICAL = 1'b0, SHIFT_ARITH = 1'b1
//       - default WIDTH = 32
//   - One sub-module, shift_stage #(WIDTH, DIST):
//       - inputs: data, en, fill
//       - output: en ? {{DIST{fill}}, data[WIDTH-1:DIST]} : data
//       - barrel_shifter instantiates SHAMT_W of these via generate, DIST = 2**k.
//   - Top level holds the bit-reverse logic, fill-bit computation and the output register.
// TESTING
//   1. rst=1 for 2 cycles with a=32'hFFFF_FFFF -> out=0. Deassert rst with a=32'h8000_0000,
//      shamt=0 -> out=32'h8000_0000 after one edge.
//   2. a=32'h8000_0000, dir=0, type=0, shamt=3 -> out=32'h0000_0000.
//      a=32'h0000_0001, shamt=31 -> out=32'h8000_0000.
//   3. a=32'h8000_0000, dir=1, type=0, shamt=1 -> out=32'h4000_0000.
//      shamt=31 -> out=32'h0000_0001.
//   4. a=32'h8000_0000, dir=1, type=1, shamt=1 -> out=32'hC000_0000.
//      shamt=31 -> out=32'hFFFF_FFFF. a=32'h7000_0000, shamt=4 -> out=32'h0700_0000.
//   5. Left shift with type=1: a=32'h0000_00F0, dir=0, type=1, shamt=4 -> out=32'h0000_0F00
//      (same as logical).
//   6. Back-to-back inputs change every cycle for 1000 random vectors -> each out matches
//      the reference model one cycle later. Pulse rst mid-stream -> out=0 on that cycle only.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the execute-stage barrel shifter.
//   DIR_LEFT / DIR_RIGHT          : encodings of the dir input
//   SHIFT_LOGICAL / SHIFT_ARITH   : encodings of the shift_type input
//   DEFAULT_WIDTH                 : operand width used when the top is not overridden
package shift_pkg;

  localparam logic DIR_LEFT      = 1'b0;
  localparam logic DIR_RIGHT     = 1'b1;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

  localparam int   DEFAULT_WIDTH = 32;

endpackage : shift_pkg

// File: rtl/shift_stage.sv
// One stage of the right-shift mux network.
// When en is set the word moves right by DIST bits and the vacated MSBs take
// the fill bit; otherwise the word passes through unchanged.
//   data   in  WIDTH  word entering this stage
//   en     in  1      shift enable (the matching shamt bit)
//   fill   in  1      value shifted into the vacated MSBs
//   result out WIDTH  word leaving this stage
module shift_stage #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  assign result = en ? {{DIST{fill}}, data[WIDTH-1:DIST]} : data;

endmodule : shift_stage

// File: rtl/barrel_shifter.sv
// 32-bit barrel shifter for the execute stage shift instructions.
// A log2(WIDTH)-stage right-shift network serves all three operations: left
// shifts reverse the operand on the way in and the result on the way out, so
// the same network (with fill 0) produces a << shamt. The result is registered,
// giving one cycle of latency into the ALU result mux.
//   clk        in  1        rising-edge clock
//   rst        in  1        synchronous, active-high reset; clears out
//   shamt      in  SHAMT_W  shift amount, 0..WIDTH-1
//   a          in  WIDTH    operand
//   shift_type in  1        SHIFT_LOGICAL / SHIFT_ARITH (right shifts only);
//                           named shift_type because 'type' is a reserved word
//   dir        in  1        DIR_LEFT / DIR_RIGHT
//   out        out WIDTH    registered shift result
module barrel_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   a,
  input  logic               shift_type,
  input  logic               dir,
  output logic [WIDTH-1:0]   out
);

  logic             is_left;
  logic             fill;
  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] core_out_rev;
  logic [WIDTH-1:0] result;

  // stage_data[k] feeds stage k; stage_data[SHAMT_W] is the network output.
  logic [WIDTH-1:0] stage_data [SHAMT_W+1];

  assign is_left = (dir == DIR_LEFT);

  // Only a right arithmetic shift drags the sign bit in; left shifts and
  // logical right shifts always fill with zero.
  assign fill = (dir == DIR_RIGHT) && (shift_type == SHIFT_ARITH) && a[WIDTH-1];

  // NOTE: every bit of a combinational output is assigned on every pass through
  // the block, so no storage (latch) is inferred.
  always_comb begin
    a_rev        = '0;
    core_out_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_rev[i]        = a[WIDTH-1-i];
      core_out_rev[i] = stage_data[SHAMT_W][WIDTH-1-i];
    end
  end

  assign stage_data[0] = is_left ? a_rev : a;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (2**k)
    ) u_stage (
      .data   (stage_data[k]),
      .en     (shamt[k]),
      .fill   (fill),
      .result (stage_data[k+1])
    );
  end

  assign result = is_left ? core_out_rev : stage_data[SHAMT_W];

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples its inputs as they were before the edge.
  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= result;
  end

endmodule : barrel_shifter

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: a table of directed vectors followed
// by back-to-back random operations with a reset pulse in the middle. Each
// expected result is queued when its inputs are driven and compared once the
// output register has captured it.
module tb_barrel_shifter;
  import shift_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] shamt;
  logic [W-1:0]  a;
  logic          shift_type;
  logic          dir;
  logic [W-1:0]  out;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string         name;
    logic          rst;
    logic [W-1:0]  a;
    logic [SW-1:0] shamt;
    logic          stype;
    logic          dir;
    logic [W-1:0]  exp;
  } vec_t;

  barrel_shifter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .shamt      (shamt),
    .a          (a),
    .shift_type (shift_type),
    .dir        (dir),
    .out        (out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_shift(logic [W-1:0] x, logic [SW-1:0] s,
                                             logic t, logic d);
    logic signed [W-1:0] xs;
    xs = x;
    if (d == DIR_LEFT)         return x << s;
    else if (t == SHIFT_ARITH) return W'(xs >>> s);
    else                       return x >> s;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one operation away from the active edge, queue its expectation, and
  // compare just after the edge that registers it.
  task automatic apply(input string name, input logic r, input logic [W-1:0] av,
                       input logic [SW-1:0] s, input logic t, input logic d,
                       input logic [W-1:0] exp);
    exp_t e;
    @(negedge clk);
    rst        = r;
    a          = av;
    shamt      = s;
    shift_type = t;
    dir        = d;
    sb.push_back('{exp: exp, name: name});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, out, exp);
    end else begin
      e = sb.pop_front();
      check(e.name, out, e.exp);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0]  ra;
    logic [SW-1:0] rs;
    logic          rt, rd, rr;
    int            rst_at;

    rst = 1'b1; a = '0; shamt = '0; shift_type = 1'b0; dir = 1'b0;

    vecs = '{
      '{"reset_0",       1'b1, 32'hFFFF_FFFF, 5'd0,  1'b0, 1'b0, 32'h0000_0000},
      '{"reset_1",       1'b1, 32'hFFFF_FFFF, 5'd7,  1'b1, 1'b1, 32'h0000_0000},
      '{"first_after",   1'b0, 32'h8000_0000, 5'd0,  1'b0, 1'b0, 32'h8000_0000},
      '{"sll_3_msb",     1'b0, 32'h8000_0000, 5'd3,  1'b0, 1'b0, 32'h0000_0000},
      '{"sll_31",        1'b0, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000},
      '{"srl_1",         1'b0, 32'h8000_0000, 5'd1,  1'b0, 1'b1, 32'h4000_0000},
      '{"srl_31",        1'b0, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'h0000_0001},
      '{"sra_1",         1'b0, 32'h8000_0000, 5'd1,  1'b1, 1'b1, 32'hC000_0000},
      '{"sra_31",        1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF},
      '{"sra_pos_4",     1'b0, 32'h7000_0000, 5'd4,  1'b1, 1'b1, 32'h0700_0000},
      '{"sll_type1",     1'b0, 32'h0000_00F0, 5'd4,  1'b1, 1'b0, 32'h0000_0F00},
      '{"sll_0_type1",   1'b0, 32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF},
      '{"srl_0",         1'b0, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 32'hDEAD_BEEF},
      '{"sra_0",         1'b0, 32'hDEAD_BEEF, 5'd0,  1'b1, 1'b1, 32'hDEAD_BEEF},
      '{"sll_31_odd",    1'b0, 32'h1234_5679, 5'd31, 1'b0, 1'b0, 32'h8000_0000},
      '{"srl_31_pos",    1'b0, 32'h7FFF_FFFF, 5'd31, 1'b0, 1'b1, 32'h0000_0000},
      '{"sra_31_pos",    1'b0, 32'h7FFF_FFFF, 5'd31, 1'b1, 1'b1, 32'h0000_0000},
      '{"srl_16",        1'b0, 32'hA5A5_0F0F, 5'd16, 1'b0, 1'b1, 32'h0000_A5A5},
      '{"sra_16",        1'b0, 32'hA5A5_0F0F, 5'd16, 1'b1, 1'b1, 32'hFFFF_A5A5},
      '{"sll_8",         1'b0, 32'hA5A5_0F0F, 5'd8,  1'b0, 1'b0, 32'hA50F_0F00},
      '{"sra_5",         1'b0, 32'h8765_4321, 5'd5,  1'b1, 1'b1, 32'hFC3B_2A19},
      '{"rst_mid",       1'b1, 32'h1234_5678, 5'd2,  1'b0, 1'b0, 32'h0000_0000},
      '{"after_rst_mid", 1'b0, 32'h1234_5678, 5'd2,  1'b0, 1'b0, 32'h48D1_59E0}
    };

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].rst, vecs[i].a, vecs[i].shamt,
            vecs[i].stype, vecs[i].dir, vecs[i].exp);

    // Back-to-back random stream, with a single-cycle reset pulse partway in.
    rst_at = 400 + int'($urandom_range(0, 200));
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rs = SW'($urandom_range(0, W-1));
      rt = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      rr = (i == rst_at);
      apply($sformatf("rand_%0d%s", i, rr ? "_rst" : ""), rr, ra, rs, rt, rd,
            rr ? '0 : ref_shift(ra, rs, rt, rd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_barrel_shifter
